// File: rtl/logit_frame_packer_if.sv
// Handshake bundle for logit_frame_packer: serial logit stream in, parallel score vector out.
// The sat_hit flag exists only when LOGIT_SAT_EN is defined.
interface logit_frame_packer_if #(
    parameter int inputBits  = 16,
    parameter int dataBits   = 16,
    parameter int numClasses = 10
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [dataBits-1:0]  in_data;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [inputBits-1:0] out [numClasses-1:0];
    logic                        err_len;
`ifdef LOGIT_SAT_EN
    logic                        sat_hit;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out, err_len, sat_hit
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out, err_len, sat_hit
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out, err_len
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out, err_len
    );
`endif
endinterface

// File: rtl/logit_frame_packer.sv
// Packs numClasses serial logits into a held parallel vector for the argmax stage.
// Optional LOGIT_SAT_EN: accBits-wide input saturated to inputBits, plus a sat_hit flag.
module logit_frame_packer #(
    parameter int inputBits  = 16,
    parameter int accBits    = 32,
    parameter int numClasses = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    logit_frame_packer_if.slave bus
);
    localparam int idx_bits = (numClasses > 1) ? $clog2(numClasses) : 1;
    localparam logic [idx_bits-1:0] last_idx = idx_bits'(numClasses - 1);

    generate
        if (accBits < inputBits) begin : g_bad_acc_bits
            $error("logit_frame_packer: accBits must be >= inputBits");
        end
    endgenerate

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [idx_bits-1:0]         idx_q, idx_d;
    logic                        err_q, err_d;
    logic                        wr_en;
    logic                        accept;
    logic signed [inputBits-1:0] beat_data;
    logic signed [inputBits-1:0] frame_buf [numClasses-1:0];

    assign bus.in_ready  = (state_q == FILL);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.err_len   = err_q;
    assign bus.out       = frame_buf;
    assign accept        = bus.in_valid & bus.in_ready;

`ifdef LOGIT_SAT_EN
    localparam logic signed [accBits-1:0] sat_max =
        {{(accBits-inputBits+1){1'b0}}, {(inputBits-1){1'b1}}};
    localparam logic signed [accBits-1:0] sat_min =
        {{(accBits-inputBits+1){1'b1}}, {(inputBits-1){1'b0}}};

    logic sat_beat;
    logic sat_q;

    always_comb begin
        sat_beat  = 1'b0;
        beat_data = bus.in_data[inputBits-1:0];
        if (bus.in_data > sat_max) begin
            sat_beat  = 1'b1;
            beat_data = sat_max[inputBits-1:0];
        end else if (bus.in_data < sat_min) begin
            sat_beat  = 1'b1;
            beat_data = sat_min[inputBits-1:0];
        end
    end

    // Sticky per frame; restarts on the first beat of every frame and on release of a held vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (state_q == HOLD && bus.out_ready) begin
            sat_q <= 1'b0;
        end else if (accept) begin
            sat_q <= ((idx_q == '0) ? 1'b0 : sat_q) | sat_beat;
        end
    end

    assign bus.sat_hit = sat_q;
`else
    assign beat_data = bus.in_data;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (idx_q == last_idx) begin
                        idx_d = '0;
                        if (bus.in_last) begin
                            state_d = HOLD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (bus.in_last) begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: this small register file is reset on purpose: a reset must clear the visible vector at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < numClasses; i++) begin
                frame_buf[i] <= '0;
            end
        end else if (wr_en) begin
            frame_buf[idx_q] <= beat_data;
        end
    end
endmodule

// File: tb/tb_logit_frame_packer.sv
// Directed self-checking bench for logit_frame_packer; saturation steps run only with LOGIT_SAT_EN.
module tb_logit_frame_packer;
`ifdef LOGIT_SAT_EN
    localparam int W = 32;
`else
    localparam int W = 16;
`endif
    localparam int N = 10;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    logit_frame_packer_if #(.inputBits(16), .dataBits(W), .numClasses(N)) bus ();

    logit_frame_packer #(.inputBits(16), .accBits(32), .numClasses(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int i, input int exp);
        logic [15:0] e;
        e = 16'(exp);
        check($sformatf("%s out[%0d]", tag, i), {16'b0, bus.out[i]}, {16'b0, e});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = W'(d);
        bus.in_last  = l;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
    endtask

    initial begin
        int frame2 [N];
        frame2 = '{-5, 100, -32768, 32767, 0, 1, 2, 3, 4, 5};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst err_len", 32'(bus.err_len), 32'd0);
        for (int i = 0; i < N; i++) check_out("rst", i, 0);
`ifdef LOGIT_SAT_EN
        check("rst sat_hit", 32'(bus.sat_hit), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 0..9 with out_ready high
        bus.out_ready = 1'b1;
        for (int i = 0; i < N - 1; i++) begin
            beat(i, 1'b0);
            check("f1 out_valid early", 32'(bus.out_valid), 32'd0);
            check("f1 err_len", 32'(bus.err_len), 32'd0);
        end
        beat(N - 1, 1'b1);
        check("f1 out_valid", 32'(bus.out_valid), 32'd1);
        check("f1 in_ready", 32'(bus.in_ready), 32'd0);
        check("f1 err_len last", 32'(bus.err_len), 32'd0);
        for (int i = 0; i < N; i++) check_out("f1", i, i);
        step();
        check("f1 release out_valid", 32'(bus.out_valid), 32'd0);
        check("f1 release in_ready", 32'(bus.in_ready), 32'd1);

        // Held frame with out_ready low and junk offered during HOLD
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) beat(frame2[i], i == N - 1);
        check("f2 out_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = W'(16'h1111);
        bus.in_last  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            check("f2 hold out_valid", 32'(bus.out_valid), 32'd1);
            check("f2 hold in_ready", 32'(bus.in_ready), 32'd0);
        end
        for (int i = 0; i < N; i++) check_out("f2 hold", i, frame2[i]);
`ifdef LOGIT_SAT_EN
        check("f2 sat_hit", 32'(bus.sat_hit), 32'd0);
`endif
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("f2 release out_valid", 32'(bus.out_valid), 32'd0);
        check("f2 release in_ready", 32'(bus.in_ready), 32'd1);
        check("f2 release err_len", 32'(bus.err_len), 32'd0);
        check_out("f2 after", 0, -5);

        // Short frame: in_last on index 4, then a frame of 7s
        for (int i = 0; i < 5; i++) beat(80 + i, i == 4);
        check("short err_len", 32'(bus.err_len), 32'd1);
        check("short out_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("short err_len drop", 32'(bus.err_len), 32'd0);
        check("short out_valid drop", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < N; i++) beat(7, i == N - 1);
        check("sevens out_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < N; i++) check_out("sevens", i, 7);
        step();
        check("sevens release", 32'(bus.out_valid), 32'd0);

        // Long frame: 10 beats without in_last, then a valid frame
        for (int i = 0; i < N; i++) beat(100 + i, 1'b0);
        check("long err_len", 32'(bus.err_len), 32'd1);
        check("long out_valid", 32'(bus.out_valid), 32'd0);
        beat(200, 1'b0);
        check("long err_len drop", 32'(bus.err_len), 32'd0);
        for (int i = 1; i < N; i++) beat(200 + i, i == N - 1);
        check("long next out_valid", 32'(bus.out_valid), 32'd1);
        check("long next err_len", 32'(bus.err_len), 32'd0);
        for (int i = 0; i < N; i++) check_out("long next", i, 200 + i);
        step();

        // Back-to-back single-beat short frames give back-to-back pulses
        beat(1, 1'b1);
        check("b2b err 1", 32'(bus.err_len), 32'd1);
        beat(2, 1'b1);
        check("b2b err 2", 32'(bus.err_len), 32'd1);
        step();
        check("b2b err drop", 32'(bus.err_len), 32'd0);

        // Reset after beat 6 of a frame
        for (int i = 0; i < 7; i++) beat(300 + i, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst mid out_valid", 32'(bus.out_valid), 32'd0);
        check("rst mid in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < N; i++) check_out("rst mid", i, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) beat(400 + i, i == N - 1);
        check("post rst out_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < N; i++) check_out("post rst", i, 400 + i);

        // Reset while holding a vector
        step();
        rst_n = 1'b0;
        #1;
        check("rst hold out_valid", 32'(bus.out_valid), 32'd0);
        check_out("rst hold", 0, 0);
        check_out("rst hold", N - 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

`ifdef LOGIT_SAT_EN
        // Saturation of 32-bit logits into 16-bit storage
        beat(70000, 1'b0);
        beat(-70000, 1'b0);
        beat(1234, 1'b0);
        for (int i = 3; i < N; i++) beat(-32768 + i, i == N - 1);
        check("sat out_valid", 32'(bus.out_valid), 32'd1);
        check_out("sat", 0, 32767);
        check_out("sat", 1, -32768);
        check_out("sat", 2, 1234);
        check_out("sat", 3, -32765);
        check("sat sat_hit", 32'(bus.sat_hit), 32'd1);
        step();
        check("sat release sat_hit", 32'(bus.sat_hit), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/logit_frame_packer.md
Name: logit_frame_packer

Overview:
- Write side of the 10-class score vector consumed by the argmax stage of the digit classifier.
- Accepts logits serially, one per valid/ready beat, from the final dense layer.
- Assembles them into a parallel signed vector and holds it for the downstream consumer until acknowledged.
- Enforces frame length and flags malformed frames.

Parameters:
- inputBits, 16: width of each stored/output signed logit.
- accBits, 32: width of in_data when LOGIT_SAT_EN is defined; ignored otherwise. Must be >= inputBits.
- numClasses, 10: logits per frame. Index counter width is $clog2(numClasses).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream logit valid.
- in_ready  output  1  block accepts a logit this cycle.
- in_data  input  inputBits (accBits with LOGIT_SAT_EN), signed: logit for the current index.
- in_last  input  1  upstream marks final logit of frame.
- out_valid  output  1  out vector complete and stable.
- out_ready  input  1  downstream accepts the vector.
- out  output  signed [inputBits-1:0] x [numClasses-1:0] (unpacked): assembled frame; out[i] is the i-th accepted logit.
- err_len  output  1  one-cycle pulse on a frame-length violation.

Behaviour:
- Reset (rst_n low, asynchronous): state FILL, idx=0, out_valid=0, err_len=0, all out[i]=0. in_ready is decoded from state, so it is 1 in FILL.
- Reset mid-frame or during HOLD discards all partial or held data immediately.
- Accept: in_valid & in_ready in the same cycle.
- FILL state: in_ready=1, out_valid=0.
  - On accept, buf[idx] <= in_data (saturated if enabled).
  - idx<numClasses-1 and in_last=0: idx++.
  - idx<numClasses-1 and in_last=1: frame too short. err_len pulses next cycle, idx<=0, frame discarded, stay FILL. Written entries are not cleared, but out_valid is never raised for them.
  - idx==numClasses-1 and in_last=1: idx<=0, go HOLD; out_valid=1 the next cycle.
  - idx==numClasses-1 and in_last=0: frame too long. err_len pulses, idx<=0, stay FILL, frame discarded. The next accepted beat is treated as index 0 of a new frame.
- HOLD state: in_ready=0, out_valid=1, out stable.
  - On out_valid & out_ready: out_valid=0 next cycle, return to FILL.
  - No same-cycle refill: the first new logit is accepted one cycle after the handshake.
- Latency: last logit accepted at edge T -> out_valid high after edge T. Minimum frame period is numClasses+1 cycles with out_ready tied high.
- out mirrors buf at all times; it changes only in FILL, never while out_valid=1.
- in_data is ignored whenever in_valid=0; in_last is ignored without accept.
- err_len is registered, high exactly one cycle per violation; back-to-back violations give back-to-back pulses.

Optional Feature:
- Macro LOGIT_SAT_EN.
- Defined:
  - in_data is accBits wide.
  - Each accepted value is saturated to the signed inputBits range: > 2^(inputBits-1)-1 -> max, < -2^(inputBits-1) -> min, else truncated to the low inputBits.
  - A sat_hit output (1 bit, reset 0) goes high on any saturated beat in the current frame. It is cleared when the block enters FILL at frame start.
- Undefined: in_data is inputBits wide and stored unmodified; accBits unused; no sat_hit port.

Test Plan:
- Reset, then 10 beats of values 0..9 with in_last on beat 9 and out_ready=1 -> out_valid high exactly one cycle after beat 9; out[i]=i; err_len stays 0.
- Frame {-5,100,-32768,32767,0,1,2,3,4,5}, out_ready held 0 for 20 cycles -> out_valid stays 1, in_ready 0, out unchanged. Raise out_ready -> out_valid=0 next cycle, in_ready=1.
- in_last asserted on beat 4 -> err_len single pulse, no out_valid. A following correct 10-beat frame of 7s -> all out[i]=7.
- 10 beats without in_last, then 10 correct beats -> err_len pulse after beat 10 (index 9), then a valid frame from the second group.
- Assert rst_n low for one cycle after beat 6 of a frame -> out_valid=0 and all out=0 immediately; the next full frame is packed correctly from index 0.
- LOGIT_SAT_EN, accBits=32: logits 70000, -70000, 1234 -> out[0]=32767, out[1]=-32768, out[2]=1234, sat_hit=1.
